screen_to_float: RTL and testbench
==================================

# screen_to_float

Sequential converter that turns signed 32-bit integer screen coordinates back into IEEE binary16 values. It is the inverse of the float-to-integer truncation stage at the end of the position-transform pipeline: rasterizer/picking logic hands it integer pixel coordinates, and it returns binary16 operands for the binary16 divide/multiply/add units used in inverse projection. A single shared normalizer is time-multiplexed across all lanes by an FSM.

## Interface

- DIMS, 3, number of coordinate lanes converted per transaction
- clk_in  input  1  single clock, all state on rising edge
- rst  input  1  reset: asynchronous, active-low
- coords  input  [DIMS-1:0][31:0]  signed two's-complement integer per lane
- data_valid_in  input  1  request; accepted only when busy is low
- result  output  [DIMS-1:0][15:0]  binary16 per lane; result[i] converts coords[i]
- data_valid_out  output  1  one-cycle pulse, result valid in that cycle
- busy  output  1  high while a transaction is in flight

## Operation

- FSM states: IDLE, LOAD, NORM, ROUND, DONE; lane index register 0..DIMS-1.
- IDLE: on data_valid_in, latch all coords, lane=0, go LOAD.
- LOAD (1 cycle): for coords[lane] v: if v ≥ 65504, lane result = 0x7BFF, skip to ROUND with bypass; if v ≤ -65504, 0xFBFF, bypass; if v == 0, result 0x0000, bypass. Otherwise sign = v[31], mag = |v| in 16-bit register, shift count = 0, go NORM if mag[15]==0, else ROUND.
- NORM: shift mag left 1, count+1 per cycle; leave to ROUND the cycle after mag[15] becomes 1 (lz cycles total, lz = leading zeros of 16-bit mag).
- ROUND (1 cycle): exponent = 30 − count; mantissa = mag[14:5]; guard = mag[4]; sticky = |mag[3:0]; round-to-nearest-even: increment when guard & (sticky | mag[5]). Mantissa carry-out (0x3FF+1) → mantissa 0, exponent+1. Write {sign, exponent[4:0], mantissa} (or bypass value) into result[lane]. If lane < DIMS−1: lane+1, go LOAD; else go DONE.
- Clamp guarantees exponent ≤ 30; no Inf/NaN/subnormal ever produced; -0 never produced.
- DONE (1 cycle): data_valid_out=1, busy=0, go IDLE; a data_valid_in in this cycle is accepted (next state LOAD, lane=0).
- data_valid_in while busy: ignored, no queuing.
- result lanes update only in ROUND of that lane; outputs hold last transaction between pulses (intermediate partial updates visible while busy are don't-care).

## Timing

- Reset (rst low, async): state IDLE, lane 0, result all 0, data_valid_out 0, busy 0. Reset mid-transaction discards it; no data_valid_out follows.
- Accept at edge T: busy high from cycle after T through last ROUND cycle.
- Per-lane cost: 2 + lz cycles (bypass/clamp/zero lanes: lz = 0).
- data_valid_out asserted in the cycle beginning at edge T + 2·DIMS + Σlz + 1; min latency 2·DIMS+1 (7 at DIMS=3), max 17·DIMS+1.
- Back-to-back: accept in DONE cycle gives zero idle cycles between transactions.

## Test plan

- coords (1, −2, 0) -> result {0x3C00, 0xC000, 0x0000}; lz 15,14,0; data_valid_out 36 cycles after accept; busy high exactly 35 cycles.
- coords (320, 180, 1024) -> {0x5D00, 0x59A0, 0x6400}, single pulse, busy low after.
- Rounding: (2049, 2051, 4095) -> {0x6800, 0x6802, 0x6C00}; (2053, 65504, 32768) -> {0x6802, 0x7BFF, 0x7800}, 65504 via clamp path.
- Clamp: (100000, −70000, −2147483648) -> {0x7BFF, 0xFBFF, 0xFBFF}, latency 7.
- Handshake: hold data_valid_in high with new coords (5, 6, 7) across a busy window -> only first request converted until DONE; request present at DONE accepted immediately, second pulse with {0x4500, 0x4600, 0x4700}.
- Reset: assert rst low mid-NORM of lane 1 -> result 0, busy 0, no data_valid_out; following request (8, 8, 8) -> {0x4800, 0x4800, 0x4800} with nominal latency.

Source files
------------

// File: rtl/screen_to_float.sv
// Signed 32-bit integer screen coordinate -> IEEE binary16, one shared
// leading-zero normalizer time-multiplexed across all lanes of a transaction.
module screen_to_float #(
   parameter int DIMS = 3
) (
   input  logic                   clk_in,
   input  logic                   rst,
   input  logic [DIMS-1:0][31:0]  coords,
   input  logic                   data_valid_in,
   output logic [DIMS-1:0][15:0]  result,
   output logic                   data_valid_out,
   output logic                   busy
);

   // Handshake: data_valid_in is sampled only in IDLE or DONE (busy low);
   // requests seen while busy are dropped. data_valid_out is a one-cycle
   // pulse in DONE, during which result holds the whole transaction.

   localparam int LANE_W = (DIMS > 1) ? $clog2(DIMS) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(DIMS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      NORM  = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [DIMS-1:0][31:0]  coords_q;
   logic [DIMS-1:0][15:0]  result_q;
   logic [LANE_W-1:0]      lane_q;
   logic [15:0]            mag_q;
   logic [3:0]             cnt_q;
   logic                   sign_q;
   logic                   bypass_q;
   logic [15:0]            bypass_val_q;

   // Lane classification in LOAD
   logic signed [31:0]     cur;
   logic                   ld_pos_clamp;
   logic                   ld_neg_clamp;
   logic                   ld_zero;
   logic                   ld_bypass;
   logic [15:0]            ld_bypass_val;
   logic [15:0]            ld_mag;

   assign cur          = coords_q[lane_q];
   assign ld_pos_clamp = (cur >= 32'sd65504);
   assign ld_neg_clamp = (cur <= -32'sd65504);
   assign ld_zero      = (cur == 32'sd0);
   assign ld_bypass    = ld_pos_clamp | ld_neg_clamp | ld_zero;

   always_comb begin
      ld_bypass_val = 16'h0000;
      if (ld_pos_clamp)      ld_bypass_val = 16'h7BFF;
      else if (ld_neg_clamp) ld_bypass_val = 16'hFBFF;
   end

   // Non-bypass magnitudes are below 65504, so the low 16 bits of the
   // negation are the full absolute value.
   assign ld_mag = cur[31] ? (~cur[15:0] + 16'd1) : cur[15:0];

   // Rounding of the normalized magnitude (mag_q[15] is the hidden bit)
   logic [4:0]  rnd_exp_base;
   logic        rnd_guard;
   logic        rnd_sticky;
   logic        rnd_inc;
   logic [10:0] rnd_mant_sum;
   logic [4:0]  rnd_exp;
   logic [15:0] rnd_word;

   assign rnd_exp_base = 5'd30 - {1'b0, cnt_q};
   assign rnd_guard    = mag_q[4];
   assign rnd_sticky   = |mag_q[3:0];
   assign rnd_inc      = rnd_guard & (rnd_sticky | mag_q[5]);
   assign rnd_mant_sum = {1'b0, mag_q[14:5]} + {10'd0, rnd_inc};
   // A mantissa carry-out leaves the low ten bits zero, so only the exponent moves.
   assign rnd_exp      = rnd_exp_base + {4'd0, rnd_mant_sum[10]};
   assign rnd_word     = {sign_q, rnd_exp, rnd_mant_sum[9:0]};

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (data_valid_in) state_d = LOAD;
         LOAD:    state_d = (ld_bypass || ld_mag[15]) ? ROUND : NORM;
         NORM:    state_d = mag_q[14] ? ROUND : NORM;
         ROUND:   state_d = (lane_q == LAST_LANE) ? DONE : LOAD;
         DONE:    state_d = data_valid_in ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         coords_q     <= '0;
         result_q     <= '0;
         lane_q       <= '0;
         mag_q        <= '0;
         cnt_q        <= '0;
         sign_q       <= 1'b0;
         bypass_q     <= 1'b0;
         bypass_val_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE, DONE: begin
               if (data_valid_in) begin
                  coords_q <= coords;
                  lane_q   <= '0;
               end
            end
            LOAD: begin
               sign_q       <= cur[31];
               mag_q        <= ld_mag;
               cnt_q        <= 4'd0;
               bypass_q     <= ld_bypass;
               bypass_val_q <= ld_bypass_val;
            end
            NORM: begin
               mag_q <= {mag_q[14:0], 1'b0};
               cnt_q <= cnt_q + 4'd1;
            end
            ROUND: begin
               result_q[lane_q] <= bypass_q ? bypass_val_q : rnd_word;
               if (lane_q != LAST_LANE) lane_q <= lane_q + LANE_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign result         = result_q;
   assign data_valid_out = (state_q == DONE);
   assign busy           = (state_q == LOAD) || (state_q == NORM) || (state_q == ROUND);

endmodule

// File: tb/tb_screen_to_float.sv
// Directed bench for screen_to_float: hand-computed binary16 results,
// pulse latency, busy window, request-while-busy and mid-flight reset.
module tb_screen_to_float;
   localparam int DIMS = 3;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [DIMS-1:0][31:0] coords = '0;
   logic                  dv_in = 1'b0;
   logic [DIMS-1:0][15:0] result;
   logic                  dv_out;
   logic                  busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   screen_to_float #(.DIMS(DIMS)) dut (
      .clk_in         (clk),
      .rst            (rst_n),
      .coords         (coords),
      .data_valid_in  (dv_in),
      .result         (result),
      .data_valid_out (dv_out),
      .busy           (busy)
   );

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Presents a request for one cycle; returns at the sample point of the
   // first cycle after the accepting edge (the first LOAD cycle).
   task automatic issue(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
      @(negedge clk);
      coords[0] = c0;
      coords[1] = c1;
      coords[2] = c2;
      dv_in     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dv_in = 1'b0;
   endtask

   // exp_k = cycles from the first LOAD cycle to the pulse = 2*DIMS + sum(lz)
   task automatic expect_txn(input string tag, input int exp_k,
                             input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
      int k;
      int busy_n;
      k = 0;
      busy_n = 0;
      while (dv_out !== 1'b1 && k < 300) begin
         if (busy === 1'b1) busy_n++;
         k++;
         @(negedge clk);
      end
      check_int($sformatf("%s.latency", tag), k, exp_k);
      check_int($sformatf("%s.busy_cycles", tag), busy_n, exp_k);
      check1($sformatf("%s.busy_at_pulse", tag), busy, 1'b0);
      check16($sformatf("%s.r0", tag), result[0], e0);
      check16($sformatf("%s.r1", tag), result[1], e1);
      check16($sformatf("%s.r2", tag), result[2], e2);
      @(negedge clk);
      check1($sformatf("%s.single_pulse", tag), dv_out, 1'b0);
   endtask

   initial begin
      int pulses;

      // Reset state
      repeat (2) @(negedge clk);
      check16("rst.r0", result[0], 16'h0000);
      check16("rst.r1", result[1], 16'h0000);
      check16("rst.r2", result[2], 16'h0000);
      check1("rst.busy", busy, 1'b0);
      check1("rst.dv_out", dv_out, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // lz = 15, 14, 0 -> 6 + 29
      issue(32'sd1, -32'sd2, 32'sd0);
      expect_txn("small", 35, 16'h3C00, 16'hC000, 16'h0000);

      // lz = 7, 8, 5
      issue(32'sd320, 32'sd180, 32'sd1024);
      expect_txn("pixel", 26, 16'h5D00, 16'h59A0, 16'h6400);
      check1("pixel.idle_busy", busy, 1'b0);

      // Rounding: tie-down, tie-up to even, mantissa carry-out; lz = 4, 4, 4
      issue(32'sd2049, 32'sd2051, 32'sd4095);
      expect_txn("round_a", 18, 16'h6800, 16'h6802, 16'h6C00);

      // Tie-to-even with odd lane, 65504 via clamp, 32768 no-shift; lz = 4, 0, 0
      issue(32'sd2053, 32'sd65504, 32'sd32768);
      expect_txn("round_b", 10, 16'h6802, 16'h7BFF, 16'h7800);

      // Clamp lanes at minimum latency
      issue(32'sd100000, -32'sd70000, 32'h8000_0000);
      expect_txn("clamp", 6, 16'h7BFF, 16'hFBFF, 16'hFBFF);

      // Request held high across a busy window with new coords
      @(negedge clk);
      coords[0] = 32'sd32768;
      coords[1] = 32'sd2053;
      coords[2] = 32'sd65504;
      dv_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      coords[0] = 32'sd5;
      coords[1] = 32'sd6;
      coords[2] = 32'sd7;
      expect_txn("hold_first", 10, 16'h7800, 16'h6802, 16'h7BFF);
      dv_in = 1'b0;
      check1("hold.accept_busy", busy, 1'b1);
      // Second request was accepted in DONE; lz = 13, 13, 13
      expect_txn("hold_second", 45, 16'h4500, 16'h4600, 16'h4700);

      // Reset in lane 1 NORM of (320, 180, 1024): lane 0 spans k0..k8, lane 1 NORM from k10
      issue(32'sd320, 32'sd180, 32'sd1024);
      repeat (12) @(negedge clk);
      check1("midrst.busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check16("midrst.r0", result[0], 16'h0000);
      check16("midrst.r1", result[1], 16'h0000);
      check16("midrst.r2", result[2], 16'h0000);
      check1("midrst.busy", busy, 1'b0);
      check1("midrst.dv_out", dv_out, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (dv_out === 1'b1) pulses++;
      end
      check_int("midrst.no_pulse", pulses, 0);
      check1("midrst.idle", busy, 1'b0);

      // lz = 12, 12, 12
      issue(32'sd8, 32'sd8, 32'sd8);
      expect_txn("after_rst", 42, 16'h4800, 16'h4800, 16'h4800);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
